dma_copy_engine: RTL and testbench

DMA_COPY_ENGINE -- requirements
Module: dma_copy_engine

---
 rtl/dma_copy_engine_if.sv | 31 +++
 rtl/dma_copy_engine.sv | 144 ++++++++++++++
 tb/tb_dma_copy_engine.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dma_copy_engine_if.sv
// Word-wide request/ack data bus between the copy engine (initiator) and memory.
// A beat completes on each rising edge where mem_request and mem_ack are both high.
interface dma_copy_engine_if;
  logic        mem_request;
  logic [31:0] mem_addr;
  logic        mem_write;
  logic [3:0]  mem_byte_enable;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  modport master (
    output mem_request,
    output mem_addr,
    output mem_write,
    output mem_byte_enable,
    output mem_wdata,
    input  mem_rdata,
    input  mem_ack
  );

  modport slave (
    input  mem_request,
    input  mem_addr,
    input  mem_write,
    input  mem_byte_enable,
    input  mem_wdata,
    output mem_rdata,
    output mem_ack
  );
endinterface

// File: rtl/dma_copy_engine.sv
// Burst memory-to-memory word copier: reads up to BURST words into a local
// buffer, writes them out, and repeats until the requested length is copied.
module dma_copy_engine #(
  parameter int BURST = 4,
  parameter int LEN_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [31:0]      src_addr,
  input  logic [31:0]      dst_addr,
  input  logic [LEN_W-1:0] length,
  output logic             busy,
  output logic             done,
  dma_copy_engine_if.master mem
);

  localparam int IDX_W = (BURST > 1) ? $clog2(BURST) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_FINISH
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [31:0]      r_src;
  logic [31:0]      r_dst;
  logic [LEN_W-1:0] r_remain;
  logic [IDX_W-1:0] r_beat;
  logic [IDX_W-1:0] r_last;
  logic [31:0]      r_buf [BURST];

  logic             w_req;
  logic             w_ack;
  logic             w_last_beat;
  logic [LEN_W-1:0] w_remain_dec;

  // Index of the final beat of a burst covering min(BURST, n) words (n != 0).
  function automatic logic [IDX_W-1:0] f_last_beat(input logic [LEN_W-1:0] n);
    if (n >= LEN_W'(BURST)) return IDX_W'(BURST - 1);
    return IDX_W'(n - LEN_W'(1));
  endfunction

  assign w_req        = reset && ((r_state == S_READ) || (r_state == S_WRITE));
  assign w_ack        = w_req && mem.mem_ack;
  assign w_last_beat  = (r_beat == r_last);
  assign w_remain_dec = r_remain - LEN_W'(1);

  always_ff @(posedge clock) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Outputs are also gated by reset so the bus reads idle for the whole reset window.
  always_comb begin
    w_next              = r_state;
    mem.mem_request     = 1'b0;
    mem.mem_write       = 1'b0;
    mem.mem_addr        = '0;
    mem.mem_wdata       = '0;
    mem.mem_byte_enable = '0;
    busy                = 1'b0;
    done                = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (start) w_next = (length == '0) ? S_FINISH : S_READ;
      end
      S_READ: begin
        if (w_ack && w_last_beat) w_next = S_WRITE;
      end
      S_WRITE: begin
        if (w_ack && w_last_beat) w_next = (w_remain_dec == '0) ? S_FINISH : S_READ;
      end
      S_FINISH: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase

    if (reset) begin
      busy = (r_state != S_IDLE);
      done = (r_state == S_FINISH);
      if (r_state == S_READ) begin
        mem.mem_request     = 1'b1;
        mem.mem_addr        = r_src;
        mem.mem_byte_enable = '1;
      end else if (r_state == S_WRITE) begin
        mem.mem_request     = 1'b1;
        mem.mem_write       = 1'b1;
        mem.mem_addr        = r_dst;
        mem.mem_wdata       = r_buf[r_beat];
        mem.mem_byte_enable = '1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_src    <= '0;
      r_dst    <= '0;
      r_remain <= '0;
      r_beat   <= '0;
      r_last   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_src    <= {src_addr[31:2], 2'b00};
            r_dst    <= {dst_addr[31:2], 2'b00};
            r_remain <= length;
            r_beat   <= '0;
            r_last   <= f_last_beat(length);
          end
        end
        S_READ: begin
          if (w_ack) begin
            r_src  <= r_src + 32'd4;
            r_beat <= w_last_beat ? '0 : r_beat + IDX_W'(1);
          end
        end
        S_WRITE: begin
          if (w_ack) begin
            r_dst    <= r_dst + 32'd4;
            r_remain <= w_remain_dec;
            if (w_last_beat) begin
              r_beat <= '0;
              r_last <= f_last_beat(w_remain_dec);
            end else begin
              r_beat <= r_beat + IDX_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if ((r_state == S_READ) && w_ack) r_buf[r_beat] <= mem.mem_rdata;
  end

endmodule

// File: tb/tb_dma_copy_engine.sv
// Bench for dma_copy_engine: randomized-latency memory responder plus a
// transaction-level reference model of the expected bus traffic.
module tb_dma_copy_engine;
  localparam int BURST = 4;
  localparam int LEN_W = 16;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             start = 1'b0;
  logic [31:0]      src_addr = '0;
  logic [31:0]      dst_addr = '0;
  logic [LEN_W-1:0] length = '0;
  logic             busy;
  logic             done;

  dma_copy_engine_if mem_bus ();

  dma_copy_engine #(.BURST(BURST), .LEN_W(LEN_W)) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .src_addr (src_addr),
    .dst_addr (dst_addr),
    .length   (length),
    .busy     (busy),
    .done     (done),
    .mem      (mem_bus)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } txn_t;

  txn_t        log_q[$];
  txn_t        exp_q[$];
  logic [31:0] mem_model [logic [31:0]];
  logic [31:0] salt = 32'h1234_5678;
  int unsigned max_wait = 0;
  int unsigned wcnt = 0;
  int unsigned done_cnt = 0;
  int unsigned req_cycles = 0;
  int unsigned viol = 0;
  int          n_pass = 0;
  int          n_fail = 0;
  int          n_total = 0;

  function automatic logic [31:0] f_data(input logic [31:0] a, input logic [31:0] s);
    return (a * 32'h9E37_79B1) ^ s;
  endfunction

  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Memory responder and bus monitor, evaluated mid-cycle.
  initial begin
    logic        p_req;
    logic        p_ack;
    logic        p_we;
    logic [31:0] p_addr;
    logic [31:0] p_wdata;
    logic [31:0] rd;
    p_req = 1'b0; p_ack = 1'b0; p_we = 1'b0; p_addr = '0; p_wdata = '0;
    mem_bus.mem_ack   = 1'b0;
    mem_bus.mem_rdata = '0;
    forever begin
      @(negedge clock);
      if (mem_bus.mem_request === 1'b1) begin
        req_cycles++;
        if (mem_bus.mem_byte_enable !== 4'hF) viol++;
        if (p_req && !p_ack && ((mem_bus.mem_addr !== p_addr) ||
            (mem_bus.mem_write !== p_we) || (mem_bus.mem_wdata !== p_wdata))) viol++;
        if (wcnt == 0) begin
          mem_bus.mem_ack = 1'b1;
          if (mem_bus.mem_write) begin
            mem_model[mem_bus.mem_addr] = mem_bus.mem_wdata;
            log_q.push_back({1'b1, mem_bus.mem_addr, mem_bus.mem_wdata});
          end else begin
            rd = mem_model.exists(mem_bus.mem_addr) ? mem_model[mem_bus.mem_addr]
                                                     : f_data(mem_bus.mem_addr, salt);
            mem_bus.mem_rdata = rd;
            log_q.push_back({1'b0, mem_bus.mem_addr, rd});
          end
          wcnt = $urandom_range(max_wait, 0);
        end else begin
          mem_bus.mem_ack   = 1'b0;
          mem_bus.mem_rdata = $urandom;
          wcnt--;
        end
      end else begin
        // Stray acks while the engine is not requesting must be ignored.
        mem_bus.mem_ack   = 1'($urandom);
        mem_bus.mem_rdata = $urandom;
        wcnt = $urandom_range(max_wait, 0);
      end
      if (done === 1'b1) done_cnt++;
      p_req   = mem_bus.mem_request;
      p_ack   = mem_bus.mem_ack;
      p_we    = mem_bus.mem_write;
      p_addr  = mem_bus.mem_addr;
      p_wdata = mem_bus.mem_wdata;
    end
  end

  task automatic run_copy(input string tag, input logic [31:0] s, input logic [31:0] d,
                          input int unsigned len, input int unsigned mw, input bit spur);
    logic [31:0] rs;
    logic [31:0] rdp;
    int unsigned rem;
    int unsigned n;
    int unsigned cyc;
    int unsigned bound;
    max_wait = mw;
    salt     = $urandom;
    log_q.delete();
    mem_model.delete();
    done_cnt = 0;
    viol     = 0;

    exp_q.delete();
    rs  = s & ~32'h3;
    rdp = d & ~32'h3;
    rem = len;
    while (rem > 0) begin
      n = (rem < BURST) ? rem : BURST;
      for (int unsigned i = 0; i < n; i++)
        exp_q.push_back({1'b0, rs + 32'(4 * i), f_data(rs + 32'(4 * i), salt)});
      for (int unsigned i = 0; i < n; i++)
        exp_q.push_back({1'b1, rdp + 32'(4 * i), f_data(rs + 32'(4 * i), salt)});
      rs  = rs + 32'(4 * n);
      rdp = rdp + 32'(4 * n);
      rem = rem - n;
    end

    start = 1'b1; src_addr = s; dst_addr = d; length = LEN_W'(len);
    @(negedge clock);
    start = 1'b0; src_addr = $urandom; dst_addr = $urandom; length = LEN_W'($urandom);
    if (spur) begin
      start = 1'b1; length = 16'd3;
      @(negedge clock);
      start = 1'b0;
    end

    bound = 100 + len * 16;
    cyc   = 0;
    while ((done !== 1'b1) && (cyc < bound)) begin
      @(negedge clock);
      cyc++;
    end
    check({tag, "_done_seen"}, 72'(cyc < bound), 72'(1));
    check({tag, "_busy_at_done"}, 72'(busy), 72'(1));
    @(negedge clock);
    check({tag, "_busy_after"}, 72'(busy), 72'(0));
    check({tag, "_done_after"}, 72'(done), 72'(0));
    check({tag, "_done_pulses"}, 72'(done_cnt), 72'(1));
    check({tag, "_stable"}, 72'(viol), 72'(0));
    check({tag, "_beats"}, 72'(log_q.size()), 72'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
      check($sformatf("%s_txn%0d", tag, i), 72'(log_q[i]), 72'(exp_q[i]));
  endtask

  initial begin
    int unsigned cyc;
    logic [31:0] r1;
    logic [31:0] r2;
    int unsigned len;

    // Reset state
    repeat (3) @(negedge clock);
    check("rst_request", 72'(mem_bus.mem_request), 72'(0));
    check("rst_write",   72'(mem_bus.mem_write),   72'(0));
    check("rst_addr",    72'(mem_bus.mem_addr),    72'(0));
    check("rst_wdata",   72'(mem_bus.mem_wdata),   72'(0));
    check("rst_be",      72'(mem_bus.mem_byte_enable), 72'(0));
    check("rst_busy",    72'(busy), 72'(0));
    check("rst_done",    72'(done), 72'(0));
    reset = 1'b1;
    @(negedge clock);
    check("idle_busy", 72'(busy), 72'(0));

    // Directed copies
    run_copy("len3",  32'h0000_0100, 32'h0000_0200, 3, 0, 1'b0);
    run_copy("len10", 32'h0000_1000, 32'h0000_2000, 10, 0, 1'b0);
    run_copy("len10w", 32'h0000_1003, 32'h0000_2002, 10, 5, 1'b0);
    run_copy("wrap",  32'hFFFF_FFFC, 32'h0000_0300, 2, 2, 1'b0);
    check("wrap_second_read", 72'(log_q.size() > 1 ? log_q[1].addr : 32'hDEAD_BEEF), 72'(0));

    // Zero length: no bus traffic, done on the cycle after start
    done_cnt = 0; req_cycles = 0;
    start = 1'b1; src_addr = 32'h0000_0400; dst_addr = 32'h0000_0500; length = '0;
    @(negedge clock);
    start = 1'b0;
    check("len0_done",  72'(done), 72'(1));
    check("len0_busy",  72'(busy), 72'(1));
    @(negedge clock);
    check("len0_done_after", 72'(done), 72'(0));
    check("len0_busy_after", 72'(busy), 72'(0));
    check("len0_no_request", 72'(req_cycles), 72'(0));
    check("len0_pulses", 72'(done_cnt), 72'(1));

    // Reset in the middle of a write burst
    max_wait = 3;
    start = 1'b1; src_addr = 32'h0000_4000; dst_addr = 32'h0000_5000; length = 16'd8;
    @(negedge clock);
    start = 1'b0;
    cyc = 0;
    while (!((mem_bus.mem_request === 1'b1) && (mem_bus.mem_write === 1'b1)) && (cyc < 200)) begin
      @(negedge clock);
      cyc++;
    end
    check("midwr_reached", 72'(cyc < 200), 72'(1));
    reset = 1'b0;
    @(negedge clock);
    check("midwr_request", 72'(mem_bus.mem_request), 72'(0));
    check("midwr_busy",    72'(busy), 72'(0));
    check("midwr_write",   72'(mem_bus.mem_write), 72'(0));
    reset = 1'b1;
    @(negedge clock);
    check("midwr_idle_busy", 72'(busy), 72'(0));
    check("midwr_idle_req",  72'(mem_bus.mem_request), 72'(0));
    run_copy("post_rst", 32'h0000_6000, 32'h0000_7000, 5, 2, 1'b0);

    // Randomized copies, some with a stray start while busy
    for (int k = 0; k < 8; k++) begin
      r1  = $urandom;
      r2  = $urandom;
      len = $urandom_range(20, 1);
      run_copy($sformatf("rnd%0d", k), {4'h1, r1[27:0]}, {4'h8, r2[27:0]},
               len, $urandom_range(5, 0), len >= 4);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
